// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, HALT word, word geometry.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    WRITE,
    CHECK,
    DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_BITS      = 8 * BYTES_PER_WORD;
  localparam logic [WORD_BITS-1:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Big-endian byte-to-word shift register with a 2-bit byte counter; word_ready marks the 4th byte.
module byte_assembler
  import program_loader_pkg::*;
#(
  parameter int DATA_BITS = WORD_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [7:0]           data_byte,
  output logic [DATA_BITS-1:0] word,
  output logic                 word_ready
);

  logic [1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      word  <= '0;
    end else if (clear) begin
      count <= '0;
      word  <= '0;
    end else if (accept) begin
      count <= count + 2'd1;
      word  <= {word[DATA_BITS-9:0], data_byte};
    end
  end

  assign word_ready = accept && (count == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Program loader: assembles received bytes into words and writes them to instruction memory.
// Optional trailing checksum byte check is built when LOADER_CHECKSUM_EN is defined.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDRESS_BITS = 8,
  parameter int DATA_BITS    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_byte_valid,
  input  logic [7:0]              i_byte,
  output logic                    o_write_enable,
  output logic [ADDRESS_BITS-1:0] o_address,
  output logic [DATA_BITS-1:0]    o_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pipeline_enable,
  output logic                    o_checksum_err
);

  state_t                  state, state_next;
  logic [ADDRESS_BITS-1:0] address;
  logic [DATA_BITS-1:0]    word;
  logic                    word_ready;
  logic                    accept;
  logic                    last_word;

  // Either a HALT word or the top address ends the load; the address never wraps.
  assign last_word = (word == HALT_WORD) || (address == '1);

  // A byte arriving in a non-final WRITE cycle is the first byte of the next word.
  always_comb begin
    accept = 1'b0;
    if (i_byte_valid && !i_start)
      accept = (state == RECEIVE) || ((state == WRITE) && !last_word);
  end

  byte_assembler #(.DATA_BITS(DATA_BITS)) u_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (i_start),
    .accept     (accept),
    .data_byte  (i_byte),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next        = state;
    o_write_enable    = 1'b0;
    o_busy            = 1'b0;
    o_done            = 1'b0;
    o_pipeline_enable = 1'b0;
    if (i_start) begin
      state_next = RECEIVE;
    end else begin
      case (state)
        IDLE:    ;
        RECEIVE: if (word_ready) state_next = WRITE;
        WRITE: begin
          if (!last_word) state_next = RECEIVE;
`ifdef LOADER_CHECKSUM_EN
          else            state_next = CHECK;
`else
          else            state_next = DONE;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK:   if (i_byte_valid) state_next = DONE;
`endif
        DONE:    ;
        default: state_next = IDLE;
      endcase
    end
    case (state)
      RECEIVE: o_busy = 1'b1;
      WRITE: begin
        o_busy         = 1'b1;
        o_write_enable = !i_start;
      end
      CHECK:   o_busy = 1'b1;
      DONE: begin
        o_done            = 1'b1;
        o_pipeline_enable = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           address <= '0;
    else if (i_start)                   address <= '0;
    else if (state == WRITE && !last_word) address <= address + ADDRESS_BITS'(1);
  end

  assign o_address = address;
  assign o_data    = o_write_enable ? word : '0;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;
  logic       checksum_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum     <= '0;
      checksum_err <= 1'b0;
    end else if (i_start) begin
      checksum     <= '0;
      checksum_err <= 1'b0;
    end else begin
      if (accept) checksum <= checksum ^ i_byte;
      if (state == CHECK && i_byte_valid) checksum_err <= (i_byte != checksum);
    end
  end

  assign o_checksum_err = checksum_err;
`else
  assign o_checksum_err = 1'b0;
`endif

endmodule
